// File: rtl/lutram_mp.sv
// Multi-read-port distributed RAM with one write port and a self-clearing sweep after reset.
// Define LUTRAM_BYPASS_EN for write-first read/write collisions; read-first otherwise.
module lutram_mp #(
  parameter int unsigned      WIDTH = 2,
  parameter int unsigned      ABITS = 5,
  parameter int unsigned      NREAD = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   we_i,
  input  logic [ABITS-1:0]       waddr_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic                   wready_o,
  output logic                   busy_o,
  input  logic [NREAD-1:0]       re_i,
  input  logic [NREAD*ABITS-1:0] raddr_i,
  output logic [NREAD*WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ABITS;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                 state_q, state_d;
  // One extra bit so the terminal compare can never alias a wrapped value.
  logic [ABITS:0]         cnt_q, cnt_d;
  logic                   last_entry;
  logic [NREAD*WIDTH-1:0] rdata_q, rdata_d;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic                   mem_we;
  logic [ABITS-1:0]       mem_waddr;
  logic [WIDTH-1:0]       mem_wdata;
  logic                   wr_acc;

  assign last_entry = (cnt_q == (ABITS+1)'(DEPTH - 1));
  assign busy_o     = (state_q == StClear);
  assign wready_o   = (state_q == StReady);
  assign wr_acc     = we_i && wready_o;
  assign rdata_o    = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StClear: begin
        cnt_d = cnt_q + (ABITS+1)'(1);
        if (last_entry) begin
          state_d = StReady;
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  // The sweep owns the write port until it finishes; user writes wait on wready_o.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr_i;
    mem_wdata = wdata_i;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q[ABITS-1:0];
      mem_wdata = INIT;
    end else if (wr_acc) begin
      mem_we    = 1'b1;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    for (int k = 0; k < NREAD; k++) begin
      if (re_i[k]) begin
        if (state_q == StClear) begin
          rdata_d[k*WIDTH +: WIDTH] = INIT;
        end else begin
          rdata_d[k*WIDTH +: WIDTH] = mem[raddr_i[k*ABITS +: ABITS]];
`ifdef LUTRAM_BYPASS_EN
          if (wr_acc && (raddr_i[k*ABITS +: ABITS] == waddr_i)) begin
            rdata_d[k*WIDTH +: WIDTH] = wdata_i;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StClear;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately unreset so it maps onto distributed RAM.
  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_lutram_mp.sv
// Scoreboard bench for lutram_mp (WIDTH=2, ABITS=5, NREAD=4, INIT=0).
module tb_lutram_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [4:0]  waddr;
  logic [1:0]  wdata;
  logic        wready;
  logic        busy;
  logic [3:0]  re;
  logic [19:0] raddr;
  logic [7:0]  rdata;

  always #5 clk = ~clk;

  lutram_mp #(
    .WIDTH(2),
    .ABITS(5),
    .NREAD(4),
    .INIT (2'b00)
  ) dut (
    .clock_i (clk),
    .reset_ni(reset_n),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .wready_o(wready),
    .busy_o  (busy),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

`ifdef LUTRAM_BYPASS_EN
  localparam logic [1:0] CollideExp = 2'b11;
`else
  localparam logic [1:0] CollideExp = 2'b00;
`endif

  typedef struct {
    int         port;
    logic [1:0] val;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  logic [3:0] re_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input int port, input logic [1:0] val, input string nm);
    exp_t e;
    e.port = port;
    e.val  = val;
    e.nm   = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Which ports were enabled at the last edge, i.e. which slices now carry fresh data.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) re_seen <= '0;
    else          re_seen <= re;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < 4; k++) begin
        if (re_seen[k]) begin
          if (q.size() == 0) begin
            chk("sb_unexpected_read", 32'(k), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.nm, "_port"}, 32'(k), 32'(e.port));
            chk(e.nm, 32'(rdata[k*2 +: 2]), 32'(e.val));
          end
        end
      end
    end
  end

  task automatic check_sweep(input string nm, input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      chk({nm, "_busy"}, 32'(busy), 32'(i < 32));
      chk({nm, "_wready"}, 32'(wready), 32'(i >= 32));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    re      = '0;
    raddr   = '0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);

    // Release with a write already pending; it must wait for the first READY edge.
    reset_n = 1'b1;
    we      = 1'b1;
    waddr   = 5'd7;
    wdata   = 2'b10;
    for (int i = 1; i <= 32; i++) begin
      step();
      chk("sweep_busy", 32'(busy), 32'(i < 32));
      chk("sweep_wready", 32'(wready), 32'(i == 32));
      if (i == 5) begin
        re          = 4'b0001;
        raddr[4:0]  = 5'd9;
        push(0, 2'b00, "clear_read");
      end else if (i == 6) begin
        re = 4'b0000;
      end
    end
    step();
    we = 1'b0;

    for (int a = 0; a < 32; a++) begin
      re         = 4'b0001;
      raddr[4:0] = 5'(a);
      push(0, (a == 7) ? 2'b10 : 2'b00, "scan");
      step();
    end
    re = 4'b0000;

    we = 1'b1;
    waddr = 5'd2; wdata = 2'b01; step();
    waddr = 5'd3; wdata = 2'b10; step();
    waddr = 5'd4; wdata = 2'b11; step();
    waddr = 5'd5; wdata = 2'b01; step();
    we = 1'b0;

    re    = 4'b1111;
    raddr = {5'd5, 5'd4, 5'd3, 5'd2};
    push(0, 2'b01, "multi_p0");
    push(1, 2'b10, "multi_p1");
    push(2, 2'b11, "multi_p2");
    push(3, 2'b01, "multi_p3");
    step();
    re = 4'b0000;

    we = 1'b1; waddr = 5'd3; wdata = 2'b00;
    step();
    we = 1'b0;
    step();
    chk("hold_p1_a", 32'(rdata[3:2]), 32'(2'b10));
    step();
    chk("hold_p1_b", 32'(rdata[3:2]), 32'(2'b10));
    re          = 4'b0010;
    raddr[9:5]  = 5'd3;
    push(1, 2'b00, "reread_p1");
    step();
    re = 4'b0000;

    we = 1'b1; waddr = 5'd6; wdata = 2'b11;
    re           = 4'b0100;
    raddr[14:10] = 5'd6;
    push(2, CollideExp, "collide");
    step();
    we = 1'b0;
    push(2, 2'b11, "after_collide");
    step();
    re = 4'b0000;
    step();
    step();
    chk("sb_drain_1", 32'(q.size()), 32'd0);
    chk("pre_reset_rdata", 32'(rdata[5:4]), 32'(2'b11));

    // Mid-operation reset must clear outputs without waiting for an edge.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rdata", 32'(rdata), 32'd0);
    chk("async_busy", 32'(busy), 32'd1);
    chk("async_wready", 32'(wready), 32'd0);
    step();
    reset_n = 1'b1;
    check_sweep("sweep2", 10);

    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midsweep_busy", 32'(busy), 32'd1);
    chk("midsweep_rdata", 32'(rdata), 32'd0);
    step();
    reset_n = 1'b1;
    check_sweep("sweep3", 32);

    re    = 4'b0011;
    raddr = {5'd0, 5'd0, 5'd3, 5'd7};
    push(0, 2'b00, "cleared_a7");
    push(1, 2'b00, "cleared_a3");
    step();
    re = 4'b0000;
    step();
    step();
    chk("sb_drain_2", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
